// File: rtl/machine_timer_bus_if.sv
// ----------------------------------------------------------------------------
// machine_timer_bus_if
// Single-beat, 32-bit, word-only peripheral bus used to reach the machine
// timer registers. There is one request per cycle, no backpressure, and a
// response exactly one cycle after each request.
//
// Signals
//   bus_en     master -> slave  request valid
//   bus_we     master -> slave  1 = write, 0 = read
//   bus_addr   master -> slave  byte offset (bits [1:0] ignored)
//   bus_wdata  master -> slave  write data
//   bus_rdata  slave -> master  read data, valid while bus_ack = 1
//   bus_ack    slave -> master  response strobe
// ----------------------------------------------------------------------------
interface machine_timer_bus_if #(
    parameter int ADDR_W = 4
);
    logic              bus_en;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [31:0]       bus_wdata;
    logic [31:0]       bus_rdata;
    logic              bus_ack;

    modport master (
        output bus_en,
        output bus_we,
        output bus_addr,
        output bus_wdata,
        input  bus_rdata,
        input  bus_ack
    );

    modport slave (
        input  bus_en,
        input  bus_we,
        input  bus_addr,
        input  bus_wdata,
        output bus_rdata,
        output bus_ack
    );
endinterface

// File: rtl/machine_timer.sv
// ----------------------------------------------------------------------------
// machine_timer
// Memory-mapped RISC-V machine timer (mtime / mtimecmp). Produces the
// machine timer-interrupt-pending level consumed by the CSR unit (mip.MTIP)
// and exports mtime for time/timeh reads.
//
// Register map (byte offset):
//   0x0 mtime[31:0]   0x4 mtime[63:32]   0x8 mtimecmp[31:0]   0xC mtimecmp[63:32]
//   offsets >= 0x10 read as 0, writes there are ignored.
//
// Parameters
//   PRESCALE  clk cycles per mtime increment, 1..2^16
//   ADDR_W    byte-offset width of the bus address, >= 4
//
// Ports
//   i_clk    clock
//   i_rst    synchronous reset, active low
//   bus      peripheral bus, slave side
//   o_tip    machine timer interrupt pending (registered mtime >= mtimecmp)
//   o_mtime  current mtime value
// ----------------------------------------------------------------------------
module machine_timer #(
    parameter int PRESCALE = 1,
    parameter int ADDR_W   = 4
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    machine_timer_bus_if.slave        bus,
    output logic                      o_tip,
    output logic [63:0]               o_mtime
);

    // Largest terminal count is 2^16 - 1, so 16 bits always suffice.
    localparam int              CNT_W   = 16;
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic [63:0]      mtime_q,    mtime_d;
    logic [63:0]      mtimecmp_q, mtimecmp_d;
    logic             tip_q,      tip_d;
    logic             ack_q,      ack_d;
    logic [31:0]      rdata_q,    rdata_d;

    logic             tick;
    logic             in_map;
    logic             wr;
    logic [1:0]       word;

    always_comb begin
        tick   = (cnt_q == CNT_TOP);
        cnt_d  = tick ? '0 : cnt_q + CNT_W'(1);

        word   = bus.bus_addr[3:2];
        in_map = ((bus.bus_addr >> 4) == '0);
        wr     = bus.bus_en && bus.bus_we && in_map;

        mtime_d    = mtime_q;
        mtimecmp_d = mtimecmp_q;

        if (tick) begin
            mtime_d = mtime_q + 64'd1;
        end

        // A bus write replaces the whole next-state value of mtime, so an
        // increment coinciding with a write to either half is discarded
        // entirely (no carry leaks into the half that was not written).
        if (wr) begin
            case (word)
                2'd0:    mtime_d    = {mtime_q[63:32], bus.bus_wdata};
                2'd1:    mtime_d    = {bus.bus_wdata, mtime_q[31:0]};
                2'd2:    mtimecmp_d = {mtimecmp_q[63:32], bus.bus_wdata};
                default: mtimecmp_d = {bus.bus_wdata, mtimecmp_q[31:0]};
            endcase
        end

        // Reads return the pre-edge register values; write responses carry 0.
        ack_d   = bus.bus_en;
        rdata_d = rdata_q;
        if (bus.bus_en) begin
            rdata_d = '0;
            if (!bus.bus_we && in_map) begin
                case (word)
                    2'd0:    rdata_d = mtime_q[31:0];
                    2'd1:    rdata_d = mtime_q[63:32];
                    2'd2:    rdata_d = mtimecmp_q[31:0];
                    default: rdata_d = mtimecmp_q[63:32];
                endcase
            end
        end

        tip_d = (mtime_q >= mtimecmp_q);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            cnt_q      <= '0;
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            tip_q      <= 1'b0;
            ack_q      <= 1'b0;
            rdata_q    <= '0;
        end else begin
            cnt_q      <= cnt_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            tip_q      <= tip_d;
            ack_q      <= ack_d;
            rdata_q    <= rdata_d;
        end
    end

    assign bus.bus_ack   = ack_q;
    assign bus.bus_rdata = rdata_q;
    assign o_tip         = tip_q;
    assign o_mtime       = mtime_q;

endmodule

// File: tb/tb_machine_timer.sv
// ----------------------------------------------------------------------------
// tb_machine_timer
// Bench for machine_timer. DUT A runs with PRESCALE = 1 and is the bus
// target; DUT B (PRESCALE = 4) sees the same bus stimulus and is used for the
// prescaler / write-collision scenario. Bus responses of DUT A are checked by
// a scoreboard: every request pushes its expected rdata and the cycle its
// ack is due; the monitor pops on each ack.
// ----------------------------------------------------------------------------
module tb_machine_timer;

    localparam int AW = 8;

    logic        clk;
    logic        rst_n;
    logic        tip_a, tip_b;
    logic [63:0] mtime_a, mtime_b;
    int          cyc;
    int          n_tests;
    int          n_fail;

    typedef struct {
        logic [31:0] exp;
        int          due;
    } sb_t;
    sb_t sb[$];

    machine_timer_bus_if #(.ADDR_W(AW)) bus_a ();
    machine_timer_bus_if #(.ADDR_W(AW)) bus_b ();

    assign bus_b.bus_en    = bus_a.bus_en;
    assign bus_b.bus_we    = bus_a.bus_we;
    assign bus_b.bus_addr  = bus_a.bus_addr;
    assign bus_b.bus_wdata = bus_a.bus_wdata;

    machine_timer #(.PRESCALE(1), .ADDR_W(AW)) u_dut_a (
        .i_clk   (clk),
        .i_rst   (rst_n),
        .bus     (bus_a),
        .o_tip   (tip_a),
        .o_mtime (mtime_a)
    );

    machine_timer #(.PRESCALE(4), .ADDR_W(AW)) u_dut_b (
        .i_clk   (clk),
        .i_rst   (rst_n),
        .bus     (bus_b),
        .o_tip   (tip_b),
        .o_mtime (mtime_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one request so it is sampled at the next posedge.
    task automatic bus_write(input logic [AW-1:0] a, input logic [31:0] d);
        bus_a.bus_en    = 1'b1;
        bus_a.bus_we    = 1'b1;
        bus_a.bus_addr  = a;
        bus_a.bus_wdata = d;
        sb.push_back('{exp: 32'h0, due: cyc + 1});
        @(posedge clk);
        #1;
        bus_a.bus_en = 1'b0;
        bus_a.bus_we = 1'b0;
    endtask

    task automatic bus_read(input logic [AW-1:0] a, input logic [31:0] exp);
        bus_a.bus_en    = 1'b1;
        bus_a.bus_we    = 1'b0;
        bus_a.bus_addr  = a;
        bus_a.bus_wdata = 32'h0;
        sb.push_back('{exp: exp, due: cyc + 1});
        @(posedge clk);
        #1;
        bus_a.bus_en = 1'b0;
    endtask

    // Response monitor for DUT A.
    always @(negedge clk) begin
        if (bus_a.bus_ack === 1'b1) begin
            if (sb.size() == 0) begin
                check_eq("spurious_ack", 64'(bus_a.bus_ack), 64'd0);
            end else begin
                check_eq("ack_cycle", 64'(cyc), 64'(sb[0].due));
                check_eq("rdata", 64'(bus_a.bus_rdata), 64'(sb[0].exp));
                void'(sb.pop_front());
            end
        end else if (sb.size() != 0 && sb[0].due <= cyc) begin
            check_eq("missing_ack", 64'(bus_a.bus_ack), 64'd1);
            void'(sb.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          hits;
        bit          found;
        logic [63:0] prev;

        n_tests = 0;
        n_fail  = 0;
        bus_a.bus_en    = 1'b0;
        bus_a.bus_we    = 1'b0;
        bus_a.bus_addr  = '0;
        bus_a.bus_wdata = '0;

        // Reset, PRESCALE = 1
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("rst_mtime", mtime_a, 64'd0);
        check_eq("rst_tip", 64'(tip_a), 64'd0);
        check_eq("rst_ack", 64'(bus_a.bus_ack), 64'd0);
        check_eq("rst_rdata", 64'(bus_a.bus_rdata), 64'd0);
        rst_n = 1'b1;
        bus_read(8'h0, 32'h0);
        bus_read(8'hC, 32'hFFFF_FFFF);
        bus_read(8'h4, 32'h0);
        hits = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tip_a !== 1'b0) hits++;
        end
        check_eq("tip_idle_100", 64'(hits), 64'd0);

        // Compare: mtime restarts at 0, cmp = 0x20
        bus_write(8'h8, 32'h20);
        bus_write(8'h4, 32'h0);
        bus_write(8'h0, 32'h0);
        bus_write(8'hC, 32'h0);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (mtime_a == 64'h20) found = 1'b1;
        end
        check_eq("reach_0x20", 64'(found), 64'd1);
        check_eq("tip_at_0x20", 64'(tip_a), 64'd0);
        @(negedge clk);
        check_eq("tip_rise", 64'(tip_a), 64'd1);
        #1;
        bus_write(8'hC, 32'h1);
        @(negedge clk);
        check_eq("tip_hold_after_wr", 64'(tip_a), 64'd1);
        @(negedge clk);
        check_eq("tip_fall", 64'(tip_a), 64'd0);

        // Carry from lo into hi (second write collides with a tick)
        #1;
        bus_write(8'h0, 32'hFFFF_FFFF);
        bus_write(8'h4, 32'h0);
        @(negedge clk);
        check_eq("carry_pre", mtime_a, 64'h0000_0000_FFFF_FFFF);
        @(negedge clk);
        check_eq("carry_post", mtime_a, 64'h0000_0001_0000_0000);

        // Wrap with cmp = 5
        #1;
        bus_write(8'h8, 32'h5);
        bus_write(8'hC, 32'h0);
        bus_write(8'h4, 32'hFFFF_FFFF);
        bus_write(8'h0, 32'hFFFF_FFFF);
        @(negedge clk);
        check_eq("wrap_ones", mtime_a, 64'hFFFF_FFFF_FFFF_FFFF);
        check_eq("wrap_tip_set", 64'(tip_a), 64'd1);
        @(negedge clk);
        check_eq("wrap_zero", mtime_a, 64'd0);
        check_eq("wrap_tip_lag", 64'(tip_a), 64'd1);
        @(negedge clk);
        check_eq("wrap_tip_fall", 64'(tip_a), 64'd0);

        // Collision on DUT B (PRESCALE = 4): find a tick, write on the next one
        prev  = mtime_b;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (mtime_b != prev) found = 1'b1;
        end
        check_eq("b_tick_seen", 64'(found), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        bus_write(8'h0, 32'h100);
        @(negedge clk);
        check_eq("b_collision_lo", 64'(mtime_b[31:0]), 64'h100);
        repeat (3) @(negedge clk);
        check_eq("b_no_early_inc", 64'(mtime_b[31:0]), 64'h100);
        @(negedge clk);
        check_eq("b_next_inc", 64'(mtime_b[31:0]), 64'h101);

        // Bus: back-to-back reads, out-of-map accesses
        #1;
        bus_write(8'h0, 32'h1000);
        bus_read(8'h0, 32'h1000);
        bus_read(8'h0, 32'h1001);
        bus_read(8'h0, 32'h1002);
        bus_read(8'h4, 32'h0);
        bus_read(8'h10, 32'h0);
        bus_write(8'h10, 32'hDEAD_BEEF);
        bus_write(8'h18, 32'h1234_5678);
        bus_read(8'h8, 32'h5);
        bus_read(8'hC, 32'h0);
        repeat (2) @(negedge clk);
        check_eq("sb_drained", 64'(sb.size()), 64'd0);

        // Reset with a read in flight: no ack afterwards
        #1;
        bus_a.bus_en   = 1'b1;
        bus_a.bus_we   = 1'b0;
        bus_a.bus_addr = 8'h0;
        rst_n          = 1'b0;
        @(posedge clk);
        #1;
        bus_a.bus_en = 1'b0;
        @(negedge clk);
        check_eq("rst_flight_ack", 64'(bus_a.bus_ack), 64'd0);
        check_eq("rst_flight_rdata", 64'(bus_a.bus_rdata), 64'd0);
        check_eq("rst_flight_mtime", mtime_a, 64'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("post_rst_ack", 64'(bus_a.bus_ack), 64'd0);
        check_eq("post_rst_sb", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
